fifo_drain_arbiter: RTL

//  Read-side scheduler for NUM_CH async_fifo instances whose read ports share the rclk domain.

---
 rtl/fifo_drain_arbiter_pkg.sv | 15 +
 rtl/fifo_drain_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_drain_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared types and helpers for the FIFO drain arbiter.
// Holds the arbiter state encoding and a width helper that never returns zero.
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Index width for n items; a single item still needs one bit of port width.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_drain_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`, wrapping.
// Rotates the request vector so the search start lands on bit 0, then priority-encodes.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             start;
  int             offset;
  int             sum;

  // NOTE: every variable is assigned before any conditional use, so no latch is inferred.
  always_comb begin
    start  = (int'(last) >= N - 1) ? 0 : int'(last) + 1;
    dbl    = {req, req} >> start;
    rot    = dbl[N-1:0];
    offset = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) offset = i;
    end
    sum = start + offset;
    if (sum >= N) sum = sum - N;
    gnt_idx = W'(sum);
    any     = |req;
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Read-side scheduler for several FIFOs sharing one read clock: round-robin bursts
// popped into a single registered valid/ready stream tagged with the source channel.
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DSIZE     = 8,
  parameter  int NUM_CH    = 4,
  parameter  int BURST_LEN = 4,
  localparam int CH_W      = clog2_min1(NUM_CH),
  localparam int CNT_W     = $clog2(BURST_LEN) + 1
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       rempty,
  input  logic [NUM_CH*DSIZE-1:0] rdata,
  output logic [NUM_CH-1:0]       rinc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DSIZE-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    busy
);

  arb_state_t        state;
  arb_state_t        state_d;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   last_gnt;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] req;
  logic              load;
  logic              pop;
  logic              xfer_exit;
  logic              sel_empty;
  logic              sel_en;
  logic [DSIZE-1:0]  sel_data;

  assign load = out_ready | ~out_valid;
  assign req  = ~rempty & ch_en;
  assign busy = (state == XFER);

  rr_pick #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_pick (
    .req     (req),
    .last    (last_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Granted channel's read port; an out-of-range grant looks empty and disabled.
  always_comb begin
    sel_data  = '0;
    sel_empty = 1'b1;
    sel_en    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt == CH_W'(i)) begin
        sel_data  = rdata[i*DSIZE +: DSIZE];
        sel_empty = rempty[i];
        sel_en    = ch_en[i];
      end
    end
  end

  // Pop strobe is combinational so a word leaves the FIFO in the same cycle it is captured.
  always_comb begin
    pop       = (state == XFER) & load & ~sel_empty & sel_en;
    xfer_exit = (pop & (cnt == CNT_W'(BURST_LEN - 1))) | sel_empty | ~sel_en;
    rinc      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rinc[i] = pop & (gnt == CH_W'(i));
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ARB:     if (pick_any) state_d = XFER;
      XFER:    if (xfer_exit) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= ARB;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      gnt       <= '0;
      last_gnt  <= CH_W'(NUM_CH - 1);
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      if (state == ARB) begin
        cnt <= '0;
        if (pick_any) gnt <= pick_idx;
      end else if (xfer_exit) begin
        last_gnt <= gnt;
      end

      // A stalled consumer (load low) leaves the output register untouched.
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= gnt;
        cnt       <= cnt + CNT_W'(1);
      end else if (load) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
